// File: rtl/hamming_pkg.sv
// Shared types and bit-layout constants for the Hamming(16,11) SECDED decoder.
// Positions follow the encoder's word layout: w[15:1] are Hamming positions, w0 is overall parity.
package hamming_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int F1_POS = 7;
    localparam int F0_POS = 6;

    localparam int D1_POS  = 3;
    localparam int D2_POS  = 5;
    localparam int D4_POS  = 7;
    localparam int D5_POS  = 9;
    localparam int D11_POS = 15;

    // Syndrome bit k covers every position 1..15 whose index has bit k set.
    localparam logic [15:0] SYN_MASK0 = 16'hAAAA;
    localparam logic [15:0] SYN_MASK1 = 16'hCCCC;
    localparam logic [15:0] SYN_MASK2 = 16'hF0F0;
    localparam logic [15:0] SYN_MASK3 = 16'hFF00;

    function automatic logic [10:0] extract_data(input logic [15:0] w);
        return {w[D11_POS:D5_POS], w[D4_POS:D2_POS], w[D1_POS]};
    endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decode of one 16-bit word into 11 data bits plus
// double-error (f1) and corrected-single-error (f0) flags.
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [15:0] w,
    output logic [11:1] d,
    output logic        f1,
    output logic        f0
);

    logic [3:0]  syn;
    logic        q;
    logic [15:0] wc;

    always_comb begin
        syn[0] = ^(w & SYN_MASK0);
        syn[1] = ^(w & SYN_MASK1);
        syn[2] = ^(w & SYN_MASK2);
        syn[3] = ^(w & SYN_MASK3);
        q      = ^w;
        wc     = w;
        // Odd overall parity with a nonzero syndrome points at the flipped bit.
        if ((syn != 4'd0) && q) begin
            wc[syn] = ~w[syn];
        end
        d  = extract_data(wc);
        f0 = q;
        f1 = (syn != 4'd0) && !q;
    end

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-walking SECDED decoder: reads NUM_WORDS encoded words, writes decoded
// data with status flags back, and counts single/double error words.
module hamming_dec_engine
    import hamming_pkg::*;
#(
    parameter int NUM_WORDS = 15,
    parameter int IN_BASE   = 30,
    parameter int OUT_BASE  = 0,
    parameter int AW        = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    output logic          Done,
    output logic [AW-1:0] MemAddr,
    input  logic [7:0]    MemRdData,
    output logic [7:0]    MemWrData,
    output logic          MemWrEn,
    output logic [3:0]    Err1Cnt,
    output logic [3:0]    Err2Cnt
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [7:0]    lo, hi;
    logic [11:1]   dec_d;
    logic          dec_f1, dec_f0;
    logic          start_ok, last_word;
    logic [AW-1:0] idx_x2, rd_base, wr_base;

    hamming_secded_dec u_dec (
        .w  ({hi, lo}),
        .d  (dec_d),
        .f1 (dec_f1),
        .f0 (dec_f0)
    );

    assign start_ok  = Start && ((state == S_IDLE) || (state == S_DONE));
    assign last_word = (idx == IW'(NUM_WORDS - 1));
    assign idx_x2    = AW'(idx) << 1;
    assign rd_base   = AW'(IN_BASE) + idx_x2;
    assign wr_base   = AW'(OUT_BASE) + idx_x2;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start_ok) state_nxt = S_RD_LO;
            S_RD_LO: state_nxt = S_RD_HI;
            S_RD_HI: state_nxt = S_WR_LO;
            S_WR_LO: state_nxt = S_WR_HI;
            S_WR_HI: state_nxt = last_word ? S_DONE : S_RD_LO;
            S_DONE:  if (start_ok) state_nxt = S_RD_LO;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            idx     <= '0;
            lo      <= '0;
            hi      <= '0;
            Err1Cnt <= '0;
            Err2Cnt <= '0;
        end else if (start_ok) begin
            idx     <= '0;
            Err1Cnt <= '0;
            Err2Cnt <= '0;
        end else begin
            if (state == S_RD_LO) lo <= MemRdData;
            if (state == S_RD_HI) hi <= MemRdData;
            if (state == S_WR_HI) begin
                if (dec_f0) Err1Cnt <= Err1Cnt + 4'd1;
                if (dec_f1) Err2Cnt <= Err2Cnt + 4'd1;
                if (!last_word) idx <= idx + IW'(1);
            end
        end
    end

    always_comb begin
        MemAddr   = '0;
        MemWrEn   = 1'b0;
        MemWrData = '0;
        Done      = (state == S_DONE);
        unique case (state)
            S_RD_LO: MemAddr = rd_base;
            S_RD_HI: MemAddr = rd_base + AW'(1);
            S_WR_LO: begin
                MemAddr   = wr_base;
                MemWrEn   = 1'b1;
                MemWrData = dec_d[8:1];
            end
            S_WR_HI: begin
                MemAddr           = wr_base + AW'(1);
                MemWrEn           = 1'b1;
                MemWrData[F1_POS] = dec_f1;
                MemWrData[F0_POS] = dec_f0;
                MemWrData[2:0]    = dec_d[11:9];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Directed-vector and random-message bench for hamming_dec_engine with a behavioural memory.
module tb_hamming_dec_engine;

    localparam int NW   = 15;
    localparam int INB  = 30;
    localparam int OUTB = 0;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Done;
    logic [7:0] MemAddr;
    logic [7:0] MemRdData;
    logic [7:0] MemWrData;
    logic       MemWrEn;
    logic [3:0] Err1Cnt;
    logic [3:0] Err2Cnt;

    logic [7:0] mem [0:255];

    hamming_dec_engine #(.NUM_WORDS(NW), .IN_BASE(INB), .OUT_BASE(OUTB), .AW(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Done      (Done),
        .MemAddr   (MemAddr),
        .MemRdData (MemRdData),
        .MemWrData (MemWrData),
        .MemWrEn   (MemWrEn),
        .Err1Cnt   (Err1Cnt),
        .Err2Cnt   (Err2Cnt)
    );

    always #5 Clk = ~Clk;

    assign MemRdData = mem[MemAddr];
    always @(posedge Clk) if (MemWrEn) mem[MemAddr] <= MemWrData;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] w;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;

    vec_t       tbl [NW];
    logic [7:0] exp_lo [NW];
    logic [7:0] exp_hi [NW];

    function automatic logic [15:0] encode(input logic [10:0] d);
        int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [15:0] w = '0;
        for (int k = 0; k < 11; k++) w[pos[k]] = d[k];
        for (int p = 1; p <= 8; p = p * 2) begin
            logic par = 1'b0;
            for (int j = 1; j < 16; j++) if (((j & p) != 0) && (j != p)) par ^= w[j];
            w[p] = par;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [15:0] model(input logic [15:0] win);
        int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [15:0] w = win;
        logic [10:0] d;
        int s = 0;
        logic q = ^win;
        logic f1, f0;
        for (int j = 1; j < 16; j++) if (win[j]) s = s ^ j;
        f0 = q;
        f1 = (s != 0) && !q;
        if ((s != 0) && q) w[s] = ~w[s];
        for (int k = 0; k < 11; k++) d[k] = w[pos[k]];
        return {f1, f0, 3'b000, d[10:8], d[7:0]};
    endfunction

    task automatic clear_out();
        for (int i = 0; i < 2 * NW; i++) mem[OUTB + i] = 8'hEE;
    endtask

    task automatic run(input int mid_start, output int done_cyc);
        done_cyc = -1;
        @(negedge Clk);
        Start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge Clk);
            Start = (cyc == mid_start);
            if (cyc == 1) begin
                chk("cyc1_addr", MemAddr, INB);
                chk("cyc1_wren", MemWrEn, 0);
                chk("cyc1_done", Done, 0);
                chk("cyc1_err1", Err1Cnt, 0);
                chk("cyc1_err2", Err2Cnt, 0);
            end
            if (cyc == 3) begin
                chk("cyc3_addr", MemAddr, OUTB);
                chk("cyc3_wren", MemWrEn, 1);
            end
            if (Done) begin
                done_cyc = cyc;
                break;
            end
        end
        Start = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < NW; i++) begin
            chk($sformatf("%s_lo%0d", tag, i), mem[OUTB + 2 * i], exp_lo[i]);
            chk($sformatf("%s_hi%0d", tag, i), mem[OUTB + 2 * i + 1], exp_hi[i]);
        end
    endtask

    initial begin
        int dc;
        int e1, e2;

        tbl[0]  = '{16'hB42D, 8'hA3, 8'h05};
        tbl[1]  = '{16'hB46D, 8'hA3, 8'h45};
        tbl[2]  = '{16'hB42C, 8'hA3, 8'h45};
        tbl[3]  = '{16'hB66D, 8'hB7, 8'h85};
        tbl[4]  = '{16'h0000, 8'h00, 8'h00};
        tbl[5]  = '{16'h0001, 8'h00, 8'h40};
        tbl[6]  = '{16'h0002, 8'h00, 8'h40};
        tbl[7]  = '{16'h0008, 8'h00, 8'h40};
        tbl[8]  = '{16'h0003, 8'h00, 8'h80};
        tbl[9]  = '{16'hFFFF, 8'hFF, 8'h07};
        tbl[10] = '{16'h7FFF, 8'hFF, 8'h47};
        tbl[11] = '{16'hFFFE, 8'hFF, 8'h47};
        tbl[12] = '{16'hB42F, 8'hA3, 8'h45};
        tbl[13] = '{16'hB52D, 8'hA3, 8'h45};
        tbl[14] = '{16'h342D, 8'hA3, 8'h45};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < NW; i++) begin
            mem[INB + 2 * i]     = tbl[i].w[7:0];
            mem[INB + 2 * i + 1] = tbl[i].w[15:8];
            exp_lo[i] = tbl[i].lo;
            exp_hi[i] = tbl[i].hi;
        end
        clear_out();

        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_done", Done, 0);
        chk("rst_wren", MemWrEn, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_wrdata", MemWrData, 0);
        chk("rst_err1", Err1Cnt, 0);
        chk("rst_err2", Err2Cnt, 0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("idle_done", Done, 0);

        // Directed run, with a Start mid-run that must be ignored.
        run(20, dc);
        chk("dir_done_cycle", dc, 61);
        check_outputs("dir");
        chk("dir_err1", Err1Cnt, 10);
        chk("dir_err2", Err2Cnt, 2);
        @(negedge Clk);
        chk("done_hold", Done, 1);
        chk("done_wren", MemWrEn, 0);

        // Restart from DONE, then reset in cycle 10.
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("restart_done_drop", Done, 0);
        chk("restart_err1_clr", Err1Cnt, 0);
        chk("restart_addr", MemAddr, INB);
        repeat (9) @(negedge Clk);
        chk("cyc10_err1", Err1Cnt, 1);
        Reset = 1'b0;
        @(negedge Clk);
        chk("midrst_wren", MemWrEn, 0);
        chk("midrst_addr", MemAddr, 0);
        chk("midrst_done", Done, 0);
        chk("midrst_err1", Err1Cnt, 0);
        chk("midrst_err2", Err2Cnt, 0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("post_rst_idle_addr", MemAddr, 0);

        // Random messages with 0, 1 or 2 flipped bits against the golden model.
        e1 = 0;
        e2 = 0;
        for (int i = 0; i < NW; i++) begin
            logic [15:0] w, r;
            int nf, p1, p2;
            w  = encode(11'($urandom_range(0, 2047)));
            nf = $urandom_range(0, 2);
            p1 = $urandom_range(0, 15);
            p2 = (p1 + $urandom_range(1, 15)) % 16;
            if (nf >= 1) w[p1] = ~w[p1];
            if (nf == 2) w[p2] = ~w[p2];
            r = model(w);
            mem[INB + 2 * i]     = w[7:0];
            mem[INB + 2 * i + 1] = w[15:8];
            exp_lo[i] = r[7:0];
            exp_hi[i] = r[15:8];
            if (r[14]) e1++;
            if (r[15]) e2++;
        end
        clear_out();
        run(30, dc);
        chk("rnd_done_cycle", dc, 61);
        check_outputs("rnd");
        chk("rnd_err1", Err1Cnt, e1);
        chk("rnd_err2", Err2Cnt, e2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
